// File: rtl/uart_rx_ctrl_if.sv
// Serial line and per-bit output strobes between the UART RX bit-timing controller
// and the deserializer it feeds.
interface uart_rx_ctrl_if;
    logic rx;
    logic data_out;
    logic shift_en;
    logic rx_done;
    logic frame_err;
    logic busy;

    modport master (
        input  rx,
        output data_out,
        output shift_en,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  shift_en,
        input  rx_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX bit-timing controller: synchronises rx, finds the start bit, samples 8 data bits
// at mid-bit (LSB first) with a shift strobe per bit, then checks the stop bit.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input logic            clk,
    input logic            rst,
    uart_rx_ctrl_if.master bus
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitIdle = 3'd4;

    localparam logic [CNT_W-1:0] HalfMax = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BitMax  = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             data_out_q, data_out_d;
    logic             sample_q, sample_d;
    logic             shift_en_q, shift_en_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;

    logic cnt_at_half;
    logic cnt_at_bit;

    assign cnt_at_half = (cnt_q == HalfMax);
    assign cnt_at_bit  = (cnt_q == BitMax);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        rx_meta_d   = bus.rx;
        rx_s_d      = rx_meta_q;
        data_out_d  = data_out_q;
        sample_d    = 1'b0;
        // Strobe trails the sample by one edge so data_out is already settled when it rises.
        shift_en_d  = sample_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_at_half) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_at_bit) begin
                    cnt_d      = '0;
                    data_out_d = rx_s_q;
                    sample_d   = 1'b1;
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_at_bit) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                // A held-low line (break) must not be mistaken for a new start bit.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            data_out_q  <= 1'b1;
            sample_q    <= 1'b0;
            shift_en_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            data_out_q  <= data_out_d;
            sample_q    <= sample_d;
            shift_en_q  <= shift_en_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.shift_en  = shift_en_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames into two instances (16 and 4 clocks per bit)
// and checks delivered bits, pulse spacing and status strobes against a frame-level model.
module tb_uart_rx_ctrl;

    logic clk;
    logic rst;
    logic rx_line;
    logic sel4;

    int vectors;
    int miscompares;

    uart_rx_ctrl_if if16 ();
    uart_rx_ctrl_if if4 ();

    assign if16.rx = sel4 ? 1'b1 : rx_line;
    assign if4.rx  = sel4 ? rx_line : 1'b1;

    uart_rx_ctrl #(.CLKS_PER_BIT(16), .CNT_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the selected instance, plus a model of the downstream deserializer.
    logic m_shift, m_data, m_done, m_err, m_busy;
    assign m_shift = sel4 ? if4.shift_en  : if16.shift_en;
    assign m_data  = sel4 ? if4.data_out  : if16.data_out;
    assign m_done  = sel4 ? if4.rx_done   : if16.rx_done;
    assign m_err   = sel4 ? if4.frame_err : if16.frame_err;
    assign m_busy  = sel4 ? if4.busy      : if16.busy;

    logic     bits_q[$];
    int       times_q[$];
    int       done_q[$];
    int       err_q[$];
    logic [7:0] shreg;
    int       consec;
    int       busy_cnt;
    logic     prev_shift;

    initial begin
        shreg      = 8'h00;
        consec     = 0;
        busy_cnt   = 0;
        prev_shift = 1'b0;
    end

    always @(negedge clk) begin
        if (m_shift === 1'b1) begin
            bits_q.push_back(m_data);
            times_q.push_back(cyc);
            shreg = {m_data, shreg[7:1]};
            if (prev_shift) consec = consec + 1;
        end
        prev_shift = (m_shift === 1'b1);
        if (m_done === 1'b1) done_q.push_back(cyc);
        if (m_err === 1'b1) err_q.push_back(cyc);
        if (m_busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic clear_mon();
        bits_q.delete();
        times_q.delete();
        done_q.delete();
        err_q.delete();
        shreg    = 8'h00;
        consec   = 0;
        busy_cnt = 0;
    endtask

    // All drive tasks enter and leave at 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb);
        drive_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
        drive_bit(stop, cpb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (if16.data_out !== 1'b1) begin miscompares++;
            $display("FAIL reset16_data_out got %b want 1", if16.data_out); end
        vectors++; if (if16.shift_en !== 1'b0) begin miscompares++;
            $display("FAIL reset16_shift_en got %b want 0", if16.shift_en); end
        vectors++; if (if16.rx_done !== 1'b0) begin miscompares++;
            $display("FAIL reset16_rx_done got %b want 0", if16.rx_done); end
        vectors++; if (if16.frame_err !== 1'b0) begin miscompares++;
            $display("FAIL reset16_frame_err got %b want 0", if16.frame_err); end
        vectors++; if (if16.busy !== 1'b0) begin miscompares++;
            $display("FAIL reset16_busy got %b want 0", if16.busy); end
        vectors++; if (if4.data_out !== 1'b1 || if4.shift_en !== 1'b0 || if4.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset4_outputs got d=%b s=%b b=%b want d=1 s=0 b=0",
                     if4.data_out, if4.shift_en, if4.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_frame_a5();
        logic [7:0] b;
        logic got;
        b = 8'hA5;
        sel4 = 1'b0;
        clear_mon();
        send_frame(b, 1'b1, 16);
        idle(24);
        vectors++; if (bits_q.size() !== 8) begin miscompares++;
            $display("FAIL a5_pulse_count got %0d want 8", bits_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
            vectors++; if (got !== b[i]) begin miscompares++;
                $display("FAIL a5_bit%0d got %b want %b", i, got, b[i]); end
        end
        for (int i = 1; i < times_q.size(); i++) begin
            vectors++; if (times_q[i] - times_q[i-1] !== 16) begin miscompares++;
                $display("FAIL a5_spacing%0d got %0d want 16", i, times_q[i] - times_q[i-1]); end
        end
        vectors++; if (shreg !== b) begin miscompares++;
            $display("FAIL a5_deser got %h want %h", shreg, b); end
        vectors++; if (done_q.size() !== 1 || err_q.size() !== 0) begin miscompares++;
            $display("FAIL a5_status got done=%0d err=%0d want done=1 err=0",
                     done_q.size(), err_q.size()); end
        if (done_q.size() == 1 && times_q.size() == 8) begin
            vectors++; if (done_q[0] - times_q[7] < 15) begin miscompares++;
                $display("FAIL a5_done_gap got %0d want >=15", done_q[0] - times_q[7]); end
        end
    endtask

    task automatic test_glitch();
        sel4 = 1'b0;
        clear_mon();
        drive_bit(1'b0, 5);
        idle(40);
        vectors++; if (bits_q.size() !== 0 || done_q.size() !== 0 || err_q.size() !== 0) begin
            miscompares++;
            $display("FAIL glitch_pulses got shift=%0d done=%0d err=%0d want 0 0 0",
                     bits_q.size(), done_q.size(), err_q.size()); end
        vectors++; if (busy_cnt !== 8) begin miscompares++;
            $display("FAIL glitch_busy_cycles got %0d want 8", busy_cnt); end
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        logic got;
        b = 8'h3C;
        sel4 = 1'b0;
        clear_mon();
        send_frame(b, 1'b0, 16);
        drive_bit(1'b0, 12);
        @(negedge clk);
        vectors++; if (if16.busy !== 1'b1) begin miscompares++;
            $display("FAIL ferr_busy_in_break got %b want 1", if16.busy); end
        @(posedge clk); #1;
        drive_bit(1'b0, 12);
        idle(40);
        vectors++; if (bits_q.size() !== 8) begin miscompares++;
            $display("FAIL ferr_pulse_count got %0d want 8", bits_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
            vectors++; if (got !== b[i]) begin miscompares++;
                $display("FAIL ferr_bit%0d got %b want %b", i, got, b[i]); end
        end
        vectors++; if (err_q.size() !== 1 || done_q.size() !== 0) begin miscompares++;
            $display("FAIL ferr_status got err=%0d done=%0d want err=1 done=0",
                     err_q.size(), done_q.size()); end
        vectors++; if (if16.busy !== 1'b0) begin miscompares++;
            $display("FAIL ferr_idle_after got busy=%b want 0", if16.busy); end
    endtask

    task automatic test_back_to_back();
        logic exp_bits[$];
        logic [7:0] bytes [2];
        logic got;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        sel4 = 1'b0;
        clear_mon();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) exp_bits.push_back(bytes[f][i]);
        send_frame(bytes[0], 1'b1, 16);
        send_frame(bytes[1], 1'b1, 16);
        idle(24);
        vectors++; if (bits_q.size() !== 16) begin miscompares++;
            $display("FAIL b2b_pulse_count got %0d want 16", bits_q.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
            vectors++; if (got !== exp_bits[i]) begin miscompares++;
                $display("FAIL b2b_bit%0d got %b want %b", i, got, exp_bits[i]); end
        end
        vectors++; if (done_q.size() !== 2) begin miscompares++;
            $display("FAIL b2b_done_count got %0d want 2", done_q.size()); end
        if (done_q.size() == 2) begin
            vectors++;
            if (done_q[1] - done_q[0] < 159 || done_q[1] - done_q[0] > 161) begin
                miscompares++;
                $display("FAIL b2b_done_spacing got %0d want 160+-1", done_q[1] - done_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic reached;
        logic got;
        b = 8'h5A;
        reached = 1'b0;
        sel4 = 1'b0;
        clear_mon();
        fork
            send_frame(b, 1'b1, 16);
            begin
                for (int k = 0; k < 400 && !reached; k++) begin
                    @(negedge clk);
                    if (bits_q.size() >= 3) reached = 1'b1;
                end
                rst = 1'b1;
                @(negedge clk);
                vectors++; if (!reached) begin miscompares++;
                    $display("FAIL rstmid_third_pulse got timeout want 3 pulses"); end
                vectors++; if (if16.data_out !== 1'b1 || if16.shift_en !== 1'b0 ||
                               if16.busy !== 1'b0 || if16.rx_done !== 1'b0 ||
                               if16.frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_outputs got d=%b s=%b b=%b dn=%b fe=%b want 1 0 0 0 0",
                             if16.data_out, if16.shift_en, if16.busy, if16.rx_done,
                             if16.frame_err); end
            end
        join
        rst = 1'b0;
        idle(24);
        vectors++; if (bits_q.size() !== 3 || done_q.size() !== 0 || err_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_pulses got shift=%0d done=%0d err=%0d want 3 0 0",
                     bits_q.size(), done_q.size(), err_q.size()); end
        clear_mon();
        b = 8'h81;
        send_frame(b, 1'b1, 16);
        idle(24);
        for (int i = 0; i < 8; i++) begin
            got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
            vectors++; if (got !== b[i]) begin miscompares++;
                $display("FAIL rstmid_81_bit%0d got %b want %b", i, got, b[i]); end
        end
        vectors++; if (shreg !== b || done_q.size() !== 1) begin miscompares++;
            $display("FAIL rstmid_81_frame got deser=%h done=%0d want %h 1",
                     shreg, done_q.size(), b); end
    endtask

    task automatic test_cpb4();
        logic [7:0] b;
        logic got;
        b = 8'h55;
        sel4 = 1'b1;
        idle(4);
        clear_mon();
        send_frame(b, 1'b1, 4);
        idle(16);
        vectors++; if (bits_q.size() !== 8) begin miscompares++;
            $display("FAIL cpb4_pulse_count got %0d want 8", bits_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
            vectors++; if (got !== b[i]) begin miscompares++;
                $display("FAIL cpb4_bit%0d got %b want %b", i, got, b[i]); end
        end
        for (int i = 1; i < times_q.size(); i++) begin
            vectors++; if (times_q[i] - times_q[i-1] !== 4) begin miscompares++;
                $display("FAIL cpb4_spacing%0d got %0d want 4", i, times_q[i] - times_q[i-1]); end
        end
        vectors++; if (consec !== 0 || done_q.size() !== 1 || err_q.size() !== 0) begin
            miscompares++;
            $display("FAIL cpb4_status got consec=%0d done=%0d err=%0d want 0 1 0",
                     consec, done_q.size(), err_q.size()); end
        sel4 = 1'b0;
        idle(4);
    endtask

    task automatic test_random();
        logic exp_bits[$];
        logic [7:0] b;
        logic got;
        int nframes;
        int cpb;
        nframes = 0;
        for (int f = 0; f < 10; f++) begin
            sel4 = ($urandom_range(0, 1) == 1);
            cpb = sel4 ? 4 : 16;
            idle(4);
            clear_mon();
            exp_bits.delete();
            nframes = $urandom_range(1, 3);
            for (int k = 0; k < nframes; k++) begin
                b = 8'($urandom);
                for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
                send_frame(b, 1'b1, cpb);
                idle($urandom_range(0, 12));
            end
            idle(3 * cpb);
            vectors++; if (bits_q.size() !== exp_bits.size()) begin miscompares++;
                $display("FAIL rand%0d_pulse_count got %0d want %0d",
                         f, bits_q.size(), exp_bits.size()); end
            for (int i = 0; i < exp_bits.size(); i++) begin
                got = (i < bits_q.size()) ? bits_q[i] : 1'bx;
                vectors++; if (got !== exp_bits[i]) begin miscompares++;
                    $display("FAIL rand%0d_bit%0d got %b want %b", f, i, got, exp_bits[i]); end
            end
            vectors++; if (done_q.size() !== nframes || err_q.size() !== 0 || consec !== 0) begin
                miscompares++;
                $display("FAIL rand%0d_status got done=%0d err=%0d consec=%0d want %0d 0 0",
                         f, done_q.size(), err_q.size(), consec, nframes); end
        end
        sel4 = 1'b0;
        idle(4);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_line     = 1'b1;
        sel4        = 1'b0;
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_cpb4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side bit-timing controller for the UART RX path.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples 8 data bits at mid-bit; each bit goes out on data_out with a qualifying shift_en pulse.
- Feeds the downstream 8-bit serial-in/parallel-out deserializer directly: data_out drives its data_in, shift_en drives its shift_en.
- Checks the stop bit and flags frame completion or framing error.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 4..65535; even values only.
CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous reset, active-high.
rx  in  1  asynchronous serial line; idles high.
data_out  out  1  sampled data bit, registered; goes to deserializer data_in.
shift_en  out  1  one-cycle registered strobe: data_out is valid, shift it in.
rx_done  out  1  one-cycle pulse: valid frame received, all 8 bits already shifted.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; baud counter, bit index, both synchroniser flops and data_out go to their reset values.
  - Synchroniser flops and data_out reset to 1.
  - shift_en, rx_done, frame_err and busy reset to 0.
  - Reset mid-frame aborts the frame with no further pulses.
- Synchroniser: two flops on rx producing rx_s; 2-cycle latency. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s=0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1:
    - rx_s=0 -> DATA, cnt=0, bit_idx=0.
    - rx_s=1 (glitch) -> IDLE, no pulses.
- DATA:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT-1 (sample edge E): data_out<=rx_s, cnt<=0.
  - Edge E+1: shift_en<=1. Edge E+2: shift_en<=0.
  - data_out is stable from E until the next sample edge, so it never changes at the edge where shift_en rises.
  - bit_idx increments at E. When bit_idx==7 at E -> STOP.
  - Bits are delivered LSB first: the first bit received ends in the deserializer's oldest stage.
- STOP:
  - At cnt==CLKS_PER_BIT-1:
    - rx_s=1 -> rx_done=1 for exactly one cycle, then IDLE.
    - rx_s=0 -> frame_err=1 for exactly one cycle, then WAIT_IDLE.
  - rx_done/frame_err are registered and assert on the cycle after the stop sample.
- WAIT_IDLE:
  - Stays until rx_s=1, then IDLE. A break condition (line held low) never retriggers a frame.
- Pulse count:
  - Exactly 8 shift_en pulses per accepted start.
  - The last pulse always precedes rx_done/frame_err by at least CLKS_PER_BIT-1 cycles.
  - shift_en is never high on two consecutive cycles.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE→START takes one cycle and the start falling edge is seen up to one cycle later; the 1/2-bit sample point absorbs this.
- data_out holds its last value when idle; the deserializer ignores it without shift_en.

Test Plan:
1. CLKS_PER_BIT=16, send 0xA5 (LSB first: 1,0,1,0,0,1,0,1), stop=1 -> 8 shift_en pulses 16 cycles apart; data_out at each pulse = 1,0,1,0,0,1,0,1; one rx_done; deserializer reads 0xA5; frame_err stays 0.
2. rx low for 5 cycles then high (glitch shorter than half bit) -> START returns to IDLE; no shift_en, rx_done or frame_err; busy high only during START.
3. Send 0x3C with stop bit 0, line held low 40 cycles, then high -> 8 shift_en pulses; frame_err pulses once; state held in WAIT_IDLE until rx high; no new frame detected during the low period.
4. Two back-to-back frames 0x00 then 0xFF, zero idle gap -> 16 shift_en pulses total; two rx_done pulses 160 cycles apart (±1); data bits correct in both frames.
5. rst asserted after the 3rd shift_en of a frame -> all outputs go to reset values on the next edge; rest of frame on rx during reset produces no pulses; next full frame 0x81 after release decodes correctly.
6. CLKS_PER_BIT=4, send 0x55 -> sample points at 4-cycle spacing; 8 correct bits; one rx_done; shift_en never high on consecutive cycles.
